// File: rtl/sparsity_pkg.sv
// Shared sparsity encodings and constants for the compressor and decompressor.
package sparsity_pkg;

  typedef enum logic [1:0] {
    SP_MODE_2_4  = 2'd0,
    SP_MODE_1_4  = 2'd1,
    SP_MODE_1_8  = 2'd2,
    SP_MODE_RSVD = 2'd3
  } sp_mode_e;

  typedef enum logic {
    SD_IDLE   = 1'b0,
    SD_ACTIVE = 1'b1
  } sd_state_e;

  localparam int IDX_W       = 3;
  localparam int GROUP_SLOTS = 4;

endpackage

// File: rtl/sparse_block_expander.sv
// Expands the four compressed slots routed to one 8-lane group into dense lanes,
// enable bits and a 2:4 index collision flag.
module sparse_block_expander
  import sparsity_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  sp_mode_e                                    mode,
  input  logic [GROUP_SLOTS-1:0][DATA_WIDTH-1:0]      slot_val,
  input  logic [GROUP_SLOTS-1:0][IDX_W-1:0]           slot_meta,
  output logic [2*GROUP_SLOTS-1:0][DATA_WIDTH-1:0]    lane_data,
  output logic [2*GROUP_SLOTS-1:0]                    lane_en,
  output logic                                        collision
);

  logic [2:0] lane;

  always_comb begin
    lane_data = '0;
    lane_en   = '0;
    collision = 1'b0;
    lane      = '0;
    case (mode)
      SP_MODE_1_4: begin
        for (int k = 0; k < 2; k++) begin
          lane            = {1'(k), slot_meta[k][1:0]};
          lane_data[lane] = slot_val[k];
          lane_en[lane]   = 1'b1;
        end
      end
      SP_MODE_1_8: begin
        lane            = slot_meta[0];
        lane_data[lane] = slot_val[0];
        lane_en[lane]   = 1'b1;
      end
      default: begin
        // Ascending slot order lets the odd slot of a colliding pair overwrite the even one.
        for (int s = 0; s < GROUP_SLOTS; s++) begin
          lane            = {1'(s / 2), slot_meta[s][1:0]};
          lane_data[lane] = slot_val[s];
          lane_en[lane]   = 1'b1;
        end
        collision = (slot_meta[0][1:0] == slot_meta[1][1:0]) ||
                    (slot_meta[2][1:0] == slot_meta[3][1:0]);
      end
    endcase
  end

endmodule

// File: rtl/sparse_decompressor.sv
// Structured-sparse stream decoder: compressed slots + position metadata in,
// dense lanes + enable mask out, one registered stage with ready/valid on both sides.
module sparse_decompressor
  import sparsity_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 16,
  parameter int BLOCK_SIZE = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [1:0]                        sparsity_mode,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH*(LANES/2)-1:0]   in_values,
  input  logic [IDX_W*(LANES/2)-1:0]        in_meta,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH*LANES-1:0]       out_data,
  output logic [LANES-1:0]                  out_enable,
  output logic                              out_last,
  output logic                              meta_error,
  output logic [15:0]                       frame_count,
  output logic [15:0]                       active_lane_count
);

  localparam int NNZ_MAX     = LANES / 2;
  localparam int GROUP_LANES = 2 * BLOCK_SIZE;
  localparam int NGROUPS     = LANES / GROUP_LANES;

  sd_state_e state;
  sp_mode_e  mode_q;
  sp_mode_e  eff_mode;
  logic      accept;

  logic [GROUP_SLOTS-1:0][DATA_WIDTH-1:0]   g_val  [NGROUPS];
  logic [GROUP_SLOTS-1:0][IDX_W-1:0]        g_meta [NGROUPS];
  logic [GROUP_LANES-1:0][DATA_WIDTH-1:0]   g_data [NGROUPS];
  logic [GROUP_LANES-1:0]                   g_en   [NGROUPS];
  logic [NGROUPS-1:0]                       g_coll;

  logic [DATA_WIDTH*LANES-1:0] dense_data;
  logic [LANES-1:0]            dense_en;
  logic [16:0]                 lane_pop;
  logic [15:0]                 alc_base;
  logic [16:0]                 alc_sum;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  // The first beat of a frame decodes with the live mode; later beats use the latched one.
  assign eff_mode = (state == SD_IDLE) ? sp_mode_e'(sparsity_mode) : mode_q;

  always_comb begin
    for (int g = 0; g < NGROUPS; g++) begin
      g_val[g]  = '0;
      g_meta[g] = '0;
      for (int j = 0; j < GROUP_SLOTS; j++) begin
        case (eff_mode)
          SP_MODE_1_4: if (j < 2) begin
            g_val[g][j]  = in_values[(2*g+j)*DATA_WIDTH +: DATA_WIDTH];
            g_meta[g][j] = in_meta[(2*g+j)*IDX_W +: IDX_W];
          end
          SP_MODE_1_8: if (j == 0) begin
            g_val[g][j]  = in_values[g*DATA_WIDTH +: DATA_WIDTH];
            g_meta[g][j] = in_meta[g*IDX_W +: IDX_W];
          end
          default: begin
            g_val[g][j]  = in_values[(GROUP_SLOTS*g+j)*DATA_WIDTH +: DATA_WIDTH];
            g_meta[g][j] = in_meta[(GROUP_SLOTS*g+j)*IDX_W +: IDX_W];
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < NGROUPS; g++) begin : g_grp
    sparse_block_expander #(.DATA_WIDTH(DATA_WIDTH)) u_expander (
      .mode      (eff_mode),
      .slot_val  (g_val[g]),
      .slot_meta (g_meta[g]),
      .lane_data (g_data[g]),
      .lane_en   (g_en[g]),
      .collision (g_coll[g])
    );
    assign dense_data[g*GROUP_LANES*DATA_WIDTH +: GROUP_LANES*DATA_WIDTH] = g_data[g];
    assign dense_en[g*GROUP_LANES +: GROUP_LANES]                         = g_en[g];
  end

  always_comb begin
    lane_pop = '0;
    for (int i = 0; i < LANES; i++) lane_pop = lane_pop + 17'(dense_en[i]);
  end

  assign alc_base = (state == SD_IDLE) ? 16'd0 : active_lane_count;
  assign alc_sum  = {1'b0, alc_base} + lane_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= SD_IDLE;
      mode_q            <= SP_MODE_2_4;
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_enable        <= '0;
      out_last          <= 1'b0;
      meta_error        <= 1'b0;
      frame_count       <= '0;
      active_lane_count <= '0;
    end else if (accept) begin
      out_valid         <= 1'b1;
      out_data          <= dense_data;
      out_enable        <= dense_en;
      out_last          <= in_last;
      meta_error        <= meta_error || (|g_coll);
      active_lane_count <= alc_sum[16] ? 16'hFFFF : alc_sum[15:0];
      if (in_last && frame_count != 16'hFFFF) frame_count <= frame_count + 16'd1;
      if (state == SD_IDLE) mode_q <= sp_mode_e'(sparsity_mode);
      state <= in_last ? SD_IDLE : SD_ACTIVE;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sparse_decompressor.sv
// Directed bench for sparse_decompressor at LANES=8 with hand-computed dense beats.
module tb_sparse_decompressor;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sparsity_mode;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_values;
  logic [11:0] in_meta;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [7:0]  out_enable;
  logic        out_last;
  logic        meta_error;
  logic [15:0] frame_count;
  logic [15:0] active_lane_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sparse_decompressor #(.DATA_WIDTH(8), .LANES(8), .BLOCK_SIZE(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .sparsity_mode     (sparsity_mode),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_values         (in_values),
    .in_meta           (in_meta),
    .in_last           (in_last),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_enable        (out_enable),
    .out_last          (out_last),
    .meta_error        (meta_error),
    .frame_count       (frame_count),
    .active_lane_count (active_lane_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] vals(input logic [7:0] v0, v1, v2, v3);
    return {v3, v2, v1, v0};
  endfunction

  function automatic logic [11:0] metas(input logic [2:0] m0, m1, m2, m3);
    return {m3, m2, m1, m0};
  endfunction

  task automatic set_beat(input logic [1:0] mode, input logic [31:0] v, input logic [11:0] m,
                          input logic last);
    sparsity_mode = mode;
    in_values     = v;
    in_meta       = m;
    in_last       = last;
    in_valid      = 1'b1;
  endtask

  // Presents a beat for exactly one edge and samples 1 time unit later.
  task automatic beat(input logic [1:0] mode, input logic [31:0] v, input logic [11:0] m,
                      input logic last);
    set_beat(mode, v, m, last);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [7:0] en, input logic [63:0] data);
    check_eq({tag, ".valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, ".enable"}, 64'(out_enable), 64'(en));
    check_eq({tag, ".data"}, out_data, data);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    sparsity_mode = 2'd0; in_values = '0; in_meta = '0; in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("rst.in_ready", 64'(in_ready), 64'd1);
    check_eq("rst.out_valid", 64'(out_valid), 64'd0);
    check_eq("rst.frame_count", 64'(frame_count), 64'd0);
    check_eq("rst.alc", 64'(active_lane_count), 64'd0);
    check_eq("rst.meta_error", 64'(meta_error), 64'd0);
    out_ready = 1'b1;

    // 2:4 single-beat frame
    beat(2'd0, vals(8'h11, 8'h22, 8'h33, 8'h44), metas(3'd1, 3'd3, 3'd0, 3'd2), 1'b1);
    check_out("t1", 8'h5A, 64'h0044_0033_2200_1100);
    check_eq("t1.last", 64'(out_last), 64'd1);
    check_eq("t1.frame_count", 64'(frame_count), 64'd1);
    check_eq("t1.alc", 64'(active_lane_count), 64'd4);
    check_eq("t1.meta_error", 64'(meta_error), 64'd0);

    // 1:8 uses slot 0 only
    beat(2'd2, vals(8'h7F, 8'h55, 8'h66, 8'h77), metas(3'd5, 3'd1, 3'd2, 3'd3), 1'b1);
    check_out("t2", 8'h20, 64'h0000_7F00_0000_0000);
    check_eq("t2.frame_count", 64'(frame_count), 64'd2);
    check_eq("t2.alc", 64'(active_lane_count), 64'd1);

    // 2:4 collision in block 0, then a clean beat with a zero-valued slot
    beat(2'd0, vals(8'hAA, 8'hBB, 8'h01, 8'h02), metas(3'd2, 3'd2, 3'd0, 3'd1), 1'b1);
    check_out("t3", 8'h34, 64'h0000_0201_00BB_0000);
    check_eq("t3.meta_error", 64'(meta_error), 64'd1);
    check_eq("t3.alc", 64'(active_lane_count), 64'd3);
    beat(2'd0, vals(8'h00, 8'h10, 8'h20, 8'h30), metas(3'd0, 3'd3, 3'd1, 3'd2), 1'b1);
    check_out("t3c", 8'h69, 64'h0030_2000_1000_0000);
    check_eq("t3c.meta_error", 64'(meta_error), 64'd1);
    check_eq("t3c.frame_count", 64'(frame_count), 64'd4);

    // 3-beat 1:4 frame; live mode change mid-frame must be ignored
    beat(2'd1, vals(8'hA1, 8'hA2, 8'hEE, 8'hEF), metas(3'd3, 3'd0, 3'd1, 3'd2), 1'b0);
    check_out("t4b1", 8'h18, 64'h0000_00A2_A100_0000);
    check_eq("t4b1.last", 64'(out_last), 64'd0);
    check_eq("t4b1.alc", 64'(active_lane_count), 64'd2);
    beat(2'd2, vals(8'hB1, 8'hB2, 8'hEE, 8'hEF), metas(3'd1, 3'd2, 3'd1, 3'd2), 1'b0);
    check_out("t4b2", 8'h42, 64'h00B2_0000_0000_B100);
    beat(2'd2, vals(8'hC1, 8'hC2, 8'hEE, 8'hEF), metas(3'd2, 3'd7, 3'd1, 3'd2), 1'b1);
    check_out("t4b3", 8'h84, 64'hC200_0000_00C1_0000);
    check_eq("t4b3.alc", 64'(active_lane_count), 64'd6);
    check_eq("t4b3.frame_count", 64'(frame_count), 64'd5);
    // Back in IDLE: a single-beat frame picks up the live 1:8 mode
    beat(2'd2, vals(8'h5A, 8'h5B, 8'h5C, 8'h5D), metas(3'd6, 3'd1, 3'd2, 3'd3), 1'b1);
    check_out("t4idle", 8'h40, 64'h005A_0000_0000_0000);
    check_eq("t4idle.alc", 64'(active_lane_count), 64'd1);

    // Backpressure: hold one beat for 4 cycles, then drain back-to-back
    @(posedge clk);
    #1;
    check_eq("t5.drain_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    beat(2'd0, vals(8'h01, 8'h02, 8'h03, 8'h04), metas(3'd0, 3'd1, 3'd2, 3'd3), 1'b0);
    check_out("t5a", 8'hC3, 64'h0403_0000_0000_0201);
    set_beat(2'd0, vals(8'h05, 8'h06, 8'h07, 8'h08), metas(3'd3, 3'd2, 3'd1, 3'd0), 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_out("t5hold", 8'hC3, 64'h0403_0000_0000_0201);
      check_eq("t5hold.in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check_eq("t5.in_ready_release", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    check_out("t5b", 8'h3C, 64'h0000_0708_0506_0000);
    beat(2'd0, vals(8'h09, 8'h0A, 8'h0B, 8'h0C), metas(3'd1, 3'd0, 3'd0, 3'd1), 1'b1);
    check_out("t5c", 8'h33, 64'h0000_0C0B_0000_090A);
    check_eq("t5c.last", 64'(out_last), 64'd1);
    check_eq("t5c.alc", 64'(active_lane_count), 64'd12);
    check_eq("t5c.frame_count", 64'(frame_count), 64'd7);
    @(posedge clk);
    #1;
    check_eq("t5.empty", 64'(out_valid), 64'd0);

    // Reset mid-frame with a held beat
    out_ready = 1'b0;
    beat(2'd1, vals(8'h21, 8'h22, 8'h23, 8'h24), metas(3'd1, 3'd2, 3'd3, 3'd0), 1'b0);
    check_eq("t6.pre_valid", 64'(out_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("t6.valid", 64'(out_valid), 64'd0);
    check_eq("t6.enable", 64'(out_enable), 64'd0);
    check_eq("t6.frame_count", 64'(frame_count), 64'd0);
    check_eq("t6.alc", 64'(active_lane_count), 64'd0);
    check_eq("t6.meta_error", 64'(meta_error), 64'd0);
    #2;
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    beat(2'd2, vals(8'h3C, 8'h31, 8'h32, 8'h33), metas(3'd5, 3'd1, 3'd2, 3'd3), 1'b0);
    check_out("t6b1", 8'h20, 64'h0000_3C00_0000_0000);
    beat(2'd0, vals(8'h4D, 8'h41, 8'h42, 8'h43), metas(3'd3, 3'd1, 3'd2, 3'd0), 1'b1);
    check_out("t6b2", 8'h08, 64'h0000_0000_4D00_0000);
    check_eq("t6b2.frame_count", 64'(frame_count), 64'd1);
    check_eq("t6b2.alc", 64'(active_lane_count), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sparse_decompressor.md
Name: sparse_decompressor

Overview:
- Decoder counterpart of the sparsity engine's masked PE feed.
- Takes a compressed structured-sparse stream (nonzero values plus per-value position metadata) from the weight/activation fetch path.
- Expands it into dense lane data plus a per-lane enable mask for the PE array.
- Supports 2:4, 1:4 and 1:8 patterns, uses ready/valid handshakes on both sides and frames data with a last flag.

Parameters:
- DATA_WIDTH, 8, bits per value.
- LANES, 16, dense output lanes. Must be a multiple of 8 and at least 8.
- BLOCK_SIZE, 4, lanes per block for 2:4 and 1:4. The 1:8 group is 2*BLOCK_SIZE.
- NNZ_MAX, LANES/2, compressed slots per beat (localparam).
- IDX_W, 3, metadata bits per slot (localparam).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- sparsity_mode  in  2  0=2:4, 1=1:4, 2=1:8, 3=reserved (decoded as 2:4)
- in_valid  in  1  compressed beat valid
- in_ready  out  1  compressed beat accepted when in_valid && in_ready
- in_values  in  DATA_WIDTH*NNZ_MAX  packed slot values, slot s at [s*DATA_WIDTH +: DATA_WIDTH]
- in_meta  in  IDX_W*NNZ_MAX  slot s position index at [s*IDX_W +: IDX_W]
- in_last  in  1  last beat of frame
- out_valid  out  1  dense beat valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_WIDTH*LANES  dense lanes; disabled lanes are zero
- out_enable  out  LANES  lane enable mask
- out_last  out  1  last beat of frame
- meta_error  out  1  sticky; set when two slots in one block collide
- frame_count  out  16  completed frames, saturating at 0xFFFF
- active_lane_count  out  16  enabled lanes accumulated over the current/last frame, saturating

Behaviour:
- Reset (async) drives all outputs to 0, the FSM to IDLE and all counters to 0. in_ready is 1 after reset because the output register is empty.
- FSM states: IDLE, ACTIVE.
  - First accepted beat in IDLE latches sparsity_mode into mode_q and clears active_lane_count before adding.
  - That beat moves the FSM to ACTIVE unless in_last=1, in which case it stays IDLE.
  - In ACTIVE, sparsity_mode changes are ignored. An accepted beat with in_last=1 returns the FSM to IDLE.
  - A single-beat frame uses the live sparsity_mode.
- Slot-to-lane mapping uses the mode of the beat.
  - 2:4: slots 2b and 2b+1 map to block b, lane = b*4 + meta[1:0]; meta[2] is ignored.
  - 1:4: slot b (b < LANES/4) maps to lane b*4 + meta[1:0]. Higher slots are ignored.
  - 1:8: slot g (g < LANES/8) maps to lane g*8 + meta[2:0]. Higher slots are ignored.
- Collision: in 2:4, if slots 2b and 2b+1 carry equal indices, slot 2b+1 wins the lane, out_enable counts that lane once, and meta_error sets. meta_error clears only on reset.
- Zero-valued slots still set their enable bit; the mask is metadata-driven, not value-driven.
- Pipeline and handshake:
  - One registered output stage; latency is 1 cycle from acceptance to out_valid.
  - in_ready = !out_valid || out_ready. This gives full throughput with no bubbles under continuous ready.
  - Output holds stable while out_valid && !out_ready. Simultaneous drain and accept loads the new beat in the same cycle.
- Counters:
  - active_lane_count adds popcount(out_enable) of each accepted beat, with 16-bit saturation.
  - frame_count increments when an in_last beat is accepted.
  - Reset mid-frame discards the held beat and returns the FSM to IDLE.

Decomposition:
- Shared package sparsity_pkg holds the mode encodings (SP_MODE_2_4, SP_MODE_1_4, SP_MODE_1_8, SP_MODE_RSVD) and the IDX_W constant. The sparsity engine reuses the same encodings.
- One sub-module, sparse_block_expander: combinational, decodes one block/group's slots and metadata into lane data, enable bits and a collision bit. It is instantiated per group via generate.

Test Plan:
1. LANES=8, mode 0, slots (val/idx) 0x11/1, 0x22/3, 0x33/0, 0x44/2, in_last=1 -> next cycle out_enable=0x5A, lanes 1/3/4/6 = 0x11/0x22/0x33/0x44, others 0, out_last=1, frame_count=1, active_lane_count=4.
2. Mode 2, slot0 0x7F/idx 5, other slots nonzero -> out_enable=0x20, lane5=0x7F; slots 1-3 ignored.
3. Mode 0, slots 0 and 1 both idx 2 (0xAA, 0xBB) -> lane2=0xBB, enable bit 2 only, meta_error=1 and stays 1 after later clean beats.
4. 3-beat frame in mode 1, sparsity_mode switched to 2 on beat 2 -> all beats decoded as 1:4, FSM returns to IDLE after beat 3, active_lane_count=6.
5. out_ready held 0 for 4 cycles with in_valid=1 -> one beat held stable, in_ready=0. Release -> back-to-back beats at 1/cycle with no loss or duplication.
6. Assert reset mid-frame with out_valid=1 -> out_valid, out_enable and counters are 0 immediately. Next beat after reset latches the new mode.
